seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/seq_window_cmp.sv | 32 +++
 rtl/seq_detect_param.sv | 110 +++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parameterised sequence detector.
package seq_det_pkg;

    // Default geometry of the detector.
    localparam int unsigned SYM_W_DEF   = 8;
    localparam int unsigned MAX_LEN_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 16;

    // Detection mode, sampled from the overlap input on each accepted symbol.
    typedef enum logic {
        NONOVERLAP = 1'b0,
        OVERLAP    = 1'b1
    } mode_e;

endpackage : seq_det_pkg

// File: rtl/seq_window_cmp.sv
// Combinational masked compare of the symbol window against the pattern.
// window_i[0] is the newest symbol; pattern_i[0] is the first pattern symbol,
// so window_i[k] lines up with pattern_i[len-1-k] for k < len.
module seq_window_cmp #(
    parameter int unsigned SYM_W   = 8,
    parameter int unsigned MAX_LEN = 8
) (
    input  logic [MAX_LEN-1:0][SYM_W-1:0]    window_i,
    input  logic [MAX_LEN-1:0][SYM_W-1:0]    pattern_i,
    input  logic [$clog2(MAX_LEN+1)-1:0]     len_i,
    output logic                             hit_o
);

    localparam int unsigned IW = $clog2(MAX_LEN);

    int unsigned len_u;

    assign len_u = 32'(len_i);

    // Hit when len is usable and every one of the newest len symbols matches.
    always_comb begin
        hit_o = (len_u != 0) && (len_u <= MAX_LEN);
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if (k < len_u) begin
                if (window_i[IW'(k)] != pattern_i[IW'(len_u - 1 - k)]) begin
                    hit_o = 1'b0;
                end
            end
        end
    end

endmodule : seq_window_cmp

// File: rtl/seq_detect_param.sv
// Programmable symbol-sequence detector with overlap/non-overlap modes,
// registered match pulse and a saturating match counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int unsigned SYM_W   = SYM_W_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic [SYM_W-1:0]              data_in,
    input  logic                          overlap,
    input  logic                          cfg_we,
    input  logic [$clog2(MAX_LEN)-1:0]    cfg_idx,
    input  logic [SYM_W-1:0]              cfg_sym,
    input  logic [$clog2(MAX_LEN+1)-1:0]  cfg_len,
    output logic                          seq_dec,
    output logic [CNT_W-1:0]              match_cnt
);

    localparam int unsigned LW = $clog2(MAX_LEN+1);

    // History (index 0 = newest) and pattern (index 0 = first symbol).
    logic [MAX_LEN-1:0][SYM_W-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0][SYM_W-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0][SYM_W-1:0] hist_shift;
    logic [LW-1:0]                 len_q, len_d;
    logic [LW-1:0]                 fill_q, fill_d;
    logic [LW-1:0]                 fill_inc;
    logic                          dec_q, dec_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          accept;
    logic                          hit;
    logic                          match;
    mode_e                         mode;

    // A symbol is taken only when no configuration write is in progress.
    assign accept     = valid & ~cfg_we;
    assign mode       = mode_e'(overlap);
    assign hist_shift = {hist_q[MAX_LEN-2:0], data_in};
    assign fill_inc   = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);

    // The compare looks at the window as it will be once this symbol is in.
    seq_window_cmp #(
        .SYM_W   (SYM_W),
        .MAX_LEN (MAX_LEN)
    ) u_cmp (
        .window_i  (hist_shift),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .hit_o     (hit)
    );

    assign match = accept & hit & (fill_inc >= len_q);

    // Next-state: configuration writes, symbol acceptance and match handling.
    always_comb begin
        hist_d = hist_q;
        pat_d  = pat_q;
        len_d  = len_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        dec_d  = 1'b0;
        if (cfg_we) begin
            if (32'(cfg_idx) < MAX_LEN) begin
                pat_d[cfg_idx] = cfg_sym;
            end
            len_d  = cfg_len;
            fill_d = '0;
        end else if (valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (match) begin
                dec_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Non-overlapping: the matched symbols may not be reused.
                if (mode == NONOVERLAP) begin
                    fill_d = '0;
                end
            end
        end
    end

    // State registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            pat_q  <= '0;
            len_q  <= '0;
            fill_q <= '0;
            dec_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            fill_q <= fill_d;
            dec_q  <= dec_d;
            cnt_q  <= cnt_d;
        end
    end

    assign seq_dec   = dec_q;
    assign match_cnt = cnt_q;

endmodule : seq_detect_param
